// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath: element geometry, opcodes and
// the element-select helper used wherever a packed result matrix is read.
package matrix_pkg;

  localparam int ELEM_W  = 8;
  localparam int DIM_MAX = 5;
  localparam int MAT_W   = ELEM_W * DIM_MAX * DIM_MAX;
  localparam int IDX_W   = 3;

  localparam logic [2:0] OP_ADD       = 3'b000;
  localparam logic [2:0] OP_SUB       = 3'b001;
  localparam logic [2:0] OP_MUL       = 3'b010;
  localparam logic [2:0] OP_TRANSPOSE = 3'b011;
  localparam logic [2:0] OP_SCALE     = 3'b100;
  localparam logic [2:0] OP_END       = 3'b111;

  // Element (row,col) always lives at the 5x5 position, whatever the active N.
  function automatic logic [ELEM_W-1:0] elem_at(input logic [MAT_W-1:0] m,
                                                input logic [IDX_W-1:0] row,
                                                input logic [IDX_W-1:0] col);
    return m[ELEM_W * (DIM_MAX * int'(row) + int'(col)) +: ELEM_W];
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (row, col) sequencer over an N x N matrix; last flags (N-1, N-1).
module matrix_index_counter
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic [IDX_W-1:0] n,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  logic col_wrap;

  assign col_wrap = (col == n - IDX_W'(1));
  assign last     = col_wrap && (row == n - IDX_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_wrap) begin
        col <= '0;
        row <= row + IDX_W'(1);
      end else begin
        col <= col + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_writeback.sv
// Streams one captured 5x5 result matrix (active N x N corner) to memory in
// row-major order, one element per cycle, with done/halted handshaking.
module matrix_writeback
  import matrix_pkg::*;
#(
  parameter int                ADDR_W           = 8,
  parameter logic [ADDR_W-1:0] MEM_BASE_DEFAULT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [MAT_W-1:0]  result,
  input  logic [7:0]        matriz_size,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              base_addr_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              halted
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            state, next_state;
  logic              accept, last, advance;
  logic [IDX_W-1:0]  n_in, cap_n, row, col, nxt_row, nxt_col;
  logic [MAT_W-1:0]  cap_mat;
  logic [ADDR_W-1:0] base_sel;

  logic              mem_we_d, busy_d, done_d, halted_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;

  assign n_in     = (matriz_size > 8'(DIM_MAX)) ? IDX_W'(DIM_MAX) : matriz_size[IDX_W-1:0];
  assign base_sel = base_addr_valid ? base_addr : MEM_BASE_DEFAULT;
  assign accept   = (state == IDLE) && start && !halted;
  assign advance  = (state == WRITE) && !last;

  matrix_index_counter u_index (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .advance (advance),
    .n       (cap_n),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  // State register plus the output registers, all fed from the comb blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= next_state;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
      done      <= done_d;
      halted    <= halted_d;
    end
  end

  // NOTE: the captured matrix is pure datapath and is only read after an
  // accept has loaded it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_mat <= result;
      cap_n   <= n_in;
    end
  end

  always_comb begin
    // NOTE: assign a default before the case so no path leaves the signal
    // unassigned, which would infer a latch.
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = (opcode == OP_END || n_in == '0) ? DONE : WRITE;
      WRITE:   if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    halted_d    = halted;
    nxt_row     = row;
    nxt_col     = col + IDX_W'(1);
    if (col == cap_n - IDX_W'(1)) begin
      nxt_row = row + IDX_W'(1);
      nxt_col = '0;
    end
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (opcode == OP_END) begin
            halted_d = 1'b1;
            done_d   = 1'b1;
          end else if (n_in == '0) begin
            done_d = 1'b1;
          end else begin
            // First element comes straight from the inputs on the capture edge.
            mem_we_d    = 1'b1;
            busy_d      = 1'b1;
            mem_addr_d  = base_sel;
            mem_wdata_d = result[ELEM_W-1:0];
          end
        end
      end
      WRITE: begin
        if (last) begin
          done_d = 1'b1;
        end else begin
          // Row-major order makes base + row*N + col a simple running increment.
          mem_we_d    = 1'b1;
          busy_d      = 1'b1;
          mem_addr_d  = mem_addr + ADDR_W'(1);
          mem_wdata_d = elem_at(cap_mat, nxt_row, nxt_col);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_writeback.sv
// Self-checking bench for matrix_writeback: directed scenarios plus random
// requests against a request-level reference model of the write stream.
module tb_matrix_writeback;
  import matrix_pkg::*;

  localparam int         ADDR_W   = 8;
  localparam logic [7:0] DEF_BASE = 8'h20;

  logic              clk = 1'b0;
  logic              reset, start, base_addr_valid;
  logic [2:0]        opcode;
  logic [MAT_W-1:0]  result;
  logic [7:0]        matriz_size;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_we, busy, done, halted;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         model_halted;
  logic [7:0] last_addr, last_data;

  always #5 clk = ~clk;

  matrix_writeback #(.ADDR_W(ADDR_W), .MEM_BASE_DEFAULT(DEF_BASE)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .opcode          (opcode),
    .result          (result),
    .matriz_size     (matriz_size),
    .base_addr       (base_addr),
    .base_addr_valid (base_addr_valid),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .busy            (busy),
    .done            (done),
    .halted          (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_elem(input logic [MAT_W-1:0] m, input int r, input int c);
    return m[8 * (5 * r + c) +: 8];
  endfunction

  function automatic logic [MAT_W-1:0] rand_matrix();
    logic [MAT_W-1:0] m;
    for (int w = 0; w < 25; w++) m[8 * w +: 8] = 8'($urandom);
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] ij_matrix();
    logic [MAT_W-1:0] m;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) m[8 * (5 * i + j) +: 8] = 8'(10 * i + j);
    return m;
  endfunction

  task automatic scramble_inputs();
    opcode          = 3'($urandom);
    result          = rand_matrix();
    matriz_size     = 8'($urandom);
    base_addr       = 8'($urandom);
    base_addr_valid = 1'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".we"},     32'(mem_we),    32'(0));
    check({tag, ".addr"},   32'(mem_addr),  32'(last_addr));
    check({tag, ".data"},   32'(mem_wdata), 32'(last_data));
    check({tag, ".busy"},   32'(busy),      32'(0));
    check({tag, ".done"},   32'(done),      32'(0));
    check({tag, ".halted"}, 32'(halted),    32'(model_halted));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset        = 1'b0;
    model_halted = 1'b0;
    last_addr    = '0;
    last_data    = '0;
    check_idle_outputs("reset");
  endtask

  // One request: start is driven for one edge, then outputs are compared
  // cycle by cycle. extra_start_at / reset_at name the observed cycle after
  // which a stray start or a reset is driven (0 = none).
  task automatic run(input string name, input logic [2:0] op, input logic [7:0] sz,
                     input logic [7:0] base, input bit bv, input logic [MAT_W-1:0] m,
                     input int extra_start_at, input int reset_at);
    int         nn, nw, idx, r, c;
    bit         ignored, aborted, exp_we, exp_done;
    logic [7:0] b, ea, ed;
    string      tag;
    nn      = (sz > 8'd5) ? 5 : int'(sz);
    b       = bv ? base : DEF_BASE;
    ignored = model_halted;
    nw      = (ignored || op == OP_END || nn == 0) ? 0 : nn * nn;
    aborted = 1'b0;

    @(negedge clk);
    opcode = op; matriz_size = sz; base_addr = base; base_addr_valid = bv; result = m;
    start  = 1'b1;
    for (int i = 1; i <= nw + 3; i++) begin
      @(negedge clk);
      tag = $sformatf("%s.c%0d", name, i);
      if (i == 1 && !ignored && op == OP_END) model_halted = 1'b1;
      if (aborted) begin
        check_idle_outputs(tag);
      end else begin
        exp_we   = (i <= nw);
        exp_done = !ignored && (i == nw + 1);
        if (exp_we) begin
          idx = i - 1; r = idx / nn; c = idx % nn;
          ea = 8'((int'(b) + r * nn + c) % 256);
          ed = ref_elem(m, r, c);
          last_addr = ea;
          last_data = ed;
        end
        check({tag, ".we"},     32'(mem_we),    32'(exp_we));
        check({tag, ".busy"},   32'(busy),      32'(exp_we));
        check({tag, ".done"},   32'(done),      32'(exp_done));
        check({tag, ".addr"},   32'(mem_addr),  32'(last_addr));
        check({tag, ".data"},   32'(mem_wdata), 32'(last_data));
        check({tag, ".halted"}, 32'(halted),    32'(model_halted));
      end
      start = 1'b0;
      reset = 1'b0;
      if (i == 1) scramble_inputs();
      if (aborted) begin
        model_halted = 1'b0;
        last_addr    = '0;
        last_data    = '0;
      end
      if (i == extra_start_at) begin
        opcode = OP_END; matriz_size = 8'd5; start = 1'b1;
      end
      if (i == reset_at) begin
        reset   = 1'b1;
        aborted = 1'b1;
        model_halted = 1'b0;
        last_addr    = '0;
        last_data    = '0;
      end
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0;
    opcode = '0; result = '0; matriz_size = '0; base_addr = '0; base_addr_valid = 1'b0;
    do_reset();

    run("n3_ij",      OP_ADD, 8'd3, 8'h10, 1'b1, ij_matrix(),   0, 0);
    run("n5_wrap",    OP_MUL, 8'd5, 8'hF0, 1'b1, rand_matrix(), 0, 0);
    run("n0",         OP_ADD, 8'd0, 8'h33, 1'b1, rand_matrix(), 0, 0);
    run("n9_default", OP_SUB, 8'd9, 8'h77, 1'b0, rand_matrix(), 0, 0);
    run("busy_start", OP_ADD, 8'd3, 8'h40, 1'b1, rand_matrix(), 4, 0);
    run("done_start", OP_ADD, 8'd2, 8'h50, 1'b1, rand_matrix(), 5, 0);
    run("n1",         OP_SCALE, 8'd1, 8'hFF, 1'b1, rand_matrix(), 0, 0);
    run("abort_n4",   OP_ADD, 8'd4, 8'h60, 1'b1, rand_matrix(), 0, 5);
    run("after_abort", OP_TRANSPOSE, 8'd2, 8'h08, 1'b1, rand_matrix(), 0, 0);

    for (int t = 0; t < 20; t++)
      run($sformatf("rand%0d", t), 3'($urandom_range(0, 6)), 8'($urandom_range(0, 9)),
          8'($urandom), 1'($urandom), rand_matrix(), 0, 0);

    run("end_op",       OP_END, 8'd3, 8'h10, 1'b1, rand_matrix(), 0, 0);
    run("halted_start", OP_ADD, 8'd3, 8'h10, 1'b1, rand_matrix(), 0, 0);
    do_reset();
    run("post_halt",    OP_ADD, 8'd2, 8'h90, 1'b1, rand_matrix(), 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_writeback.md
MATRIX_WRITEBACK -- requirements
Module: matrix_writeback

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the memory address width in bits.
REQ-002 The block SHALL have parameter MEM_BASE_DEFAULT, default 0, giving the base address used when base_addr_valid is low.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: single-cycle request to write back one result matrix.
REQ-006 Port opcode, input, 3 bits: opcode of the operation that produced result.
REQ-007 Port result, input, 200 bits: 5x5 matrix of signed 8-bit elements; element (i,j) is result[8*(5*i+j) +: 8].
REQ-008 Port matriz_size, input, 8 bits: active matrix dimension N.
REQ-009 Port base_addr, input, ADDR_W bits: destination base address.
REQ-010 Port base_addr_valid, input, 1 bit: when high, base_addr is used; when low, MEM_BASE_DEFAULT is used.
REQ-011 Port mem_we, output, 1 bit: memory write strobe.
REQ-012 Port mem_addr, output, ADDR_W bits: write address.
REQ-013 Port mem_wdata, output, 8 bits: write data.
REQ-014 Port busy, output, 1 bit: high while the block is in state WRITE.
REQ-015 Port done, output, 1 bit: one-cycle completion pulse.
REQ-016 Port halted, output, 1 bit: sticky end-of-program flag.

Function
REQ-017 States SHALL be IDLE, WRITE and DONE; reset SHALL enter IDLE.
REQ-018 In IDLE with start=1, the block SHALL capture result, opcode, the clamped N and the selected base address into internal registers at that edge.
- Clamping: matriz_size>5 becomes 5.
- Capture is independent of later input changes.
REQ-019 If the captured opcode is 3'b111, the block SHALL go to DONE with no writes and set halted.
REQ-020 If N=0, the block SHALL go to DONE with no writes.
REQ-021 Otherwise the block SHALL go to WRITE with row=0 and col=0.
REQ-022 In WRITE, each cycle SHALL assert mem_we=1 with the following, in row-major order:
- mem_addr = base + row*N + col, modulo 2^ADDR_W (wraps silently);
- mem_wdata = element (row,col) of the captured matrix.
REQ-023 In WRITE, col SHALL increment each cycle; at col=N-1 it SHALL wrap to 0 and row SHALL increment.
REQ-024 After writing (N-1,N-1), the block SHALL go to DONE.
REQ-025 The block SHALL issue exactly N*N writes per request.
REQ-026 Latency: start at edge k SHALL give the first mem_we in cycle k+1, the last in cycle k+N*N, and done=1 in cycle k+N*N+1. For the no-write cases, done SHALL be high in cycle k+1.
REQ-027 DONE SHALL last exactly one cycle and return to IDLE; a start during DONE SHALL be ignored.
REQ-028 A start while busy=1 SHALL be ignored, and the in-flight transfer SHALL be unaffected.
REQ-029 mem_we SHALL be 0 outside WRITE, and mem_addr/mem_wdata SHALL then hold their last values.
REQ-030 halted SHALL remain 1 until reset; while halted=1, start SHALL be ignored.
REQ-031 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-032 On reset=1 at a clock edge, the block SHALL go to IDLE with mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, halted=0, row=col=0.
REQ-033 Reset during WRITE SHALL abort the transfer: no further mem_we from the next cycle, and no done pulse.
REQ-034 Reset SHALL take priority over start in the same cycle.

Structure
REQ-035 A shared package matrix_pkg SHALL hold ELEM_W=8, DIM_MAX=5, MAT_W=200 and the opcode constants, including OP_END=3'b111.
REQ-036 The state encoding SHALL be local to matrix_writeback.
REQ-037 The row/col sequencing SHALL be one sub-module, matrix_index_counter, with:
- inputs clk, reset, clear, advance, N;
- outputs row, col, last.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- N=3, base 0x10, opcode 000, element(i,j)=10*i+j -> writes at 0x10..0x18 with data 0,1,2,10,11,12,20,21,22; done in cycle k+10.
- N=5, base 0xF0, ADDR_W=8 -> 25 writes; addresses wrap 0xFF->0x00 after 16 writes; last address 0x08.
- opcode 111 with N=3 -> no mem_we; done in cycle k+1; halted=1; a later start is ignored.
- N=0 -> no mem_we, done in cycle k+1; N=9 -> 25 writes.
- Second start at write 4 of an N=3 transfer -> ignored; exactly 9 writes; a single done.
- Reset asserted at write 5 of an N=4 transfer -> mem_we=0 from the next cycle; no done; all outputs at reset values.
